// File: rtl/tap_master.sv
// Scan master for a DR-only TAP target. It walks the target to RUN_TEST_IDLE, runs
// complete DR scans on command, and tracks the target's TAP state edge by edge.
module tap_master #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              tlr_req,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              cmd_err,
  output logic              busy,
  output logic [3:0]        tgt_state
);

  localparam logic [3:0] TAP_TLR   = 4'd0;
  localparam logic [3:0] TAP_RTI   = 4'd1;
  localparam logic [3:0] TAP_SEL   = 4'd2;
  localparam logic [3:0] TAP_CAP   = 4'd3;
  localparam logic [3:0] TAP_SHIFT = 4'd4;
  localparam logic [3:0] TAP_EXIT1 = 4'd5;
  localparam logic [3:0] TAP_PAUSE = 4'd6;
  localparam logic [3:0] TAP_EXIT2 = 4'd7;
  localparam logic [3:0] TAP_UPD   = 4'd8;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WALK_DROP = CNT_W'(4);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] MAX_LEN   = CNT_W'(DATA_W);

  // Each sequencer state names the target transition its next edge produces.
  typedef enum logic [2:0] {
    S_RST_WALK,
    S_IDLE,
    S_SEL,
    S_CAP,
    S_PRE,
    S_SHIFT,
    S_UPD,
    S_DONE
  } seq_t;

  seq_t              seq;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  last_idx;
  logic [DATA_W-1:0] pay;
  logic              len_ok;
  logic              take_tlr;
  logic              take_cmd;

  function automatic logic [3:0] tap_next(input logic [3:0] st, input logic m);
    case (st)
      TAP_TLR:   tap_next = m ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   tap_next = m ? TAP_SEL   : TAP_RTI;
      TAP_SEL:   tap_next = m ? TAP_TLR   : TAP_CAP;
      TAP_CAP:   tap_next = m ? TAP_EXIT1 : TAP_SHIFT;
      TAP_SHIFT: tap_next = m ? TAP_EXIT1 : TAP_SHIFT;
      TAP_EXIT1: tap_next = m ? TAP_UPD   : TAP_PAUSE;
      TAP_PAUSE: tap_next = m ? TAP_EXIT2 : TAP_PAUSE;
      TAP_EXIT2: tap_next = m ? TAP_UPD   : TAP_SHIFT;
      TAP_UPD:   tap_next = m ? TAP_SEL   : TAP_RTI;
      default:   tap_next = TAP_TLR;
    endcase
  endfunction

  assign len_ok   = (cmd_len != '0) && (cmd_len <= MAX_LEN);
  assign take_tlr = (seq == S_IDLE) && tlr_req;
  assign take_cmd = (seq == S_IDLE) && !tlr_req && cmd_valid;
  assign busy     = ~cmd_ready;

  // Payload and length are pure data: loaded at acceptance, consumed LSB first.
  always_ff @(posedge tck) begin
    if (take_cmd && len_ok) begin
      pay      <= cmd_data;
      last_idx <= cmd_len - CNT_ONE;
    end else if (seq == S_PRE || seq == S_SHIFT) begin
      pay <= pay >> 1;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      seq       <= S_RST_WALK;
      cnt       <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cmd_err   <= 1'b0;
      tgt_state <= TAP_TLR;
    end else begin
      tgt_state <= tap_next(tgt_state, tms);
      rsp_valid <= 1'b0;
      cmd_err   <= 1'b0;
      case (seq)
        S_RST_WALK: begin
          if (cnt == WALK_LAST) begin
            tms       <= 1'b0;
            cmd_ready <= 1'b1;
            cnt       <= '0;
            seq       <= S_IDLE;
          end else begin
            if (cnt == WALK_DROP) tms <= 1'b0;
            cnt <= cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          tms <= 1'b0;
          tdi <= 1'b0;
          if (take_tlr) begin
            tms       <= 1'b1;
            cmd_ready <= 1'b0;
            cnt       <= '0;
            seq       <= S_RST_WALK;
          end else if (take_cmd) begin
            if (len_ok) begin
              tms       <= 1'b1;
              cmd_ready <= 1'b0;
              rsp_data  <= '0;
              seq       <= S_SEL;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        S_SEL: begin
          tms <= 1'b0;
          seq <= S_CAP;
        end
        S_CAP: begin
          tms <= 1'b0;
          seq <= S_PRE;
        end
        S_PRE: begin
          tdi <= pay[0];
          tms <= (last_idx == '0);
          cnt <= '0;
          seq <= S_SHIFT;
        end
        // tms rises one edge early so the last shift edge also exits to EXIT1.
        S_SHIFT: begin
          rsp_data <= rsp_data | (DATA_W'(tdo) << cnt);
          if (cnt == last_idx) begin
            tdi <= 1'b0;
            tms <= 1'b1;
            seq <= S_UPD;
          end else begin
            tdi <= pay[0];
            tms <= ((cnt + CNT_ONE) == last_idx);
            cnt <= cnt + CNT_ONE;
          end
        end
        S_UPD: begin
          tms <= 1'b0;
          seq <= S_DONE;
        end
        S_DONE: begin
          rsp_valid <= 1'b1;
          cmd_ready <= 1'b1;
          seq       <= S_IDLE;
        end
        default: begin
          tms       <= 1'b1;
          cmd_ready <= 1'b0;
          cnt       <= '0;
          seq       <= S_RST_WALK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_master.sv
// Bench for tap_master: a behavioural DR-only target with a 1-bit chain drives tdo,
// and scan results are checked against expectations computed from the scan rules.
module tb_tap_master;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  logic              tck = 1'b0;
  logic              trst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              tlr_req = 1'b0;
  logic              tms;
  logic              tdi;
  logic              tdo;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              cmd_err;
  logic              busy;
  logic [3:0]        tgt_state;

  int errors = 0;
  int checks = 0;

  tap_master #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .tck(tck), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .tlr_req(tlr_req), .tms(tms),
    .tdi(tdi), .tdo(tdo), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cmd_err(cmd_err), .busy(busy), .tgt_state(tgt_state)
  );

  always #5 tck = ~tck;

  // Behavioural target: DR-only TAP with a 1-bit data register.
  logic [3:0] t_st;
  logic       t_chain;
  logic       t_cap = 1'b1;
  int         n_shift = 0;
  int         n_upd = 0;
  logic       tdi_hist[$];

  function automatic logic [3:0] tgt_next(input logic [3:0] s, input logic m);
    logic [3:0] on0 [9] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4, 4'd1};
    logic [3:0] on1 [9] = '{4'd0, 4'd2, 4'd0, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8, 4'd2};
    if (s > 4'd8) return 4'd0;
    return m ? on1[s] : on0[s];
  endfunction

  always @(posedge tck or posedge trst) begin
    if (trst) begin
      t_st    <= 4'd0;
      t_chain <= 1'b0;
    end else begin
      t_st <= tgt_next(t_st, tms);
      if (t_st == 4'd3) t_chain <= t_cap;
      if (t_st == 4'd4) begin
        t_chain <= tdi;
        n_shift <= n_shift + 1;
        tdi_hist.push_back(tdi);
      end
      if (t_st == 4'd8) n_upd <= n_upd + 1;
    end
  end

  assign tdo = t_chain;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tck);
    #1;
    chk("tgt_state_track", 64'(tgt_state), 64'(t_st));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tms"}, 64'(tms), 64'd1);
    chk({tag, "_tdi"}, 64'(tdi), 64'd0);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_cmd_err"}, 64'(cmd_err), 64'd0);
    chk({tag, "_tgt_state"}, 64'(tgt_state), 64'd0);
  endtask

  // Called with trst high, just after an edge; releases reset and checks the walk.
  task automatic reset_release_check();
    logic [63:0] obs;
    obs = '0;
    trst = 1'b0;
    obs[0] = tms;
    for (int k = 1; k <= 5; k++) begin
      step();
      obs[k] = tms;
    end
    chk("walk_tms", obs, 64'b011111);
    chk("walk_ready_early", 64'(cmd_ready), 64'd0);
    step();
    chk("walk_ready", 64'(cmd_ready), 64'd1);
    chk("walk_busy", 64'(busy), 64'd0);
    chk("walk_tgt_rti", 64'(tgt_state), 64'd1);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 60) begin
      step();
      k++;
    end
    chk("ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_scan(input int len, input logic [DATA_W-1:0] d, input logic cap,
                          input bit noisy);
    int sh0, up0, h0, resp_k;
    logic [63:0] tms_obs, tms_exp, mask, rsp_exp, tdi_obs;
    logic [DATA_W-1:0] held;
    wait_ready();
    t_cap     = cap;
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(len);
    cmd_data  = d;
    sh0 = n_shift;
    up0 = n_upd;
    h0  = tdi_hist.size();
    step();
    cmd_valid = 1'b0;
    chk("scan_busy", 64'(busy), 64'd1);
    chk("scan_rsp_cleared", 64'(rsp_data), 64'd0);
    tms_obs = '0;
    tms_obs[0] = tms;
    resp_k = -1;
    for (int e = 1; e <= DATA_W + 10; e++) begin
      if (noisy && e < len + 3) begin
        cmd_valid = 1'($urandom);
        tlr_req   = 1'($urandom);
        cmd_len   = CNT_W'($urandom);
        cmd_data  = $urandom;
      end else begin
        cmd_valid = 1'b0;
        tlr_req   = 1'b0;
      end
      step();
      if (rsp_valid) begin
        resp_k = e;
        break;
      end
      tms_obs[e] = tms;
    end
    mask    = (64'd1 << len) - 64'd1;
    rsp_exp = (({32'b0, d} << 1) | 64'(cap)) & mask;
    tms_exp = 64'd1 | (64'd1 << (len + 2)) | (64'd1 << (len + 3));
    tdi_obs = '0;
    for (int j = 0; j < len && (h0 + j) < tdi_hist.size(); j++) tdi_obs[j] = tdi_hist[h0 + j];
    chk("scan_latency", 64'(resp_k), 64'(len + 5));
    chk("scan_tms_seq", tms_obs, tms_exp);
    chk("scan_rsp_data", 64'(rsp_data), rsp_exp);
    chk("scan_ready_at_rsp", 64'(cmd_ready), 64'd1);
    chk("scan_shift_en_cycles", 64'(n_shift - sh0), 64'(len));
    chk("scan_update_en_cycles", 64'(n_upd - up0), 64'd1);
    chk("scan_tdi_bits", tdi_obs, {32'b0, d} & mask);
    held = rsp_data;
    step();
    chk("scan_rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("scan_rsp_held", 64'(rsp_data), 64'(held));
    chk("scan_idle_tms", 64'(tms), 64'd0);
    chk("scan_idle_tdi", 64'(tdi), 64'd0);
  endtask

  task automatic err_cmd(input int len);
    int sh0;
    wait_ready();
    sh0 = n_shift;
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(len);
    cmd_data  = $urandom;
    step();
    cmd_valid = 1'b0;
    chk("err_pulse", 64'(cmd_err), 64'd1);
    chk("err_ready", 64'(cmd_ready), 64'd1);
    chk("err_tms", 64'(tms), 64'd0);
    chk("err_tgt_rti", 64'(tgt_state), 64'd1);
    step();
    chk("err_pulse_end", 64'(cmd_err), 64'd0);
    chk("err_no_shift", 64'(n_shift - sh0), 64'd0);
  endtask

  task automatic tlr_test();
    logic [63:0] obs;
    logic [DATA_W-1:0] r0;
    int sh0, rv;
    wait_ready();
    r0  = rsp_data;
    sh0 = n_shift;
    rv  = 0;
    tlr_req   = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(8);
    cmd_data  = 32'h0000_00FF;
    step();
    tlr_req   = 1'b0;
    cmd_valid = 1'b0;
    obs = '0;
    obs[0] = tms;
    chk("tlr_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      obs[k] = tms;
      if (rsp_valid) rv++;
    end
    chk("tlr_tms", obs, 64'b011111);
    step();
    if (rsp_valid) rv++;
    chk("tlr_ready", 64'(cmd_ready), 64'd1);
    chk("tlr_tgt_rti", 64'(tgt_state), 64'd1);
    chk("tlr_rsp_untouched", 64'(rsp_data), 64'(r0));
    chk("tlr_no_rsp_valid", 64'(rv), 64'd0);
    chk("tlr_cmd_dropped", 64'(n_shift - sh0), 64'd0);
  endtask

  task automatic trst_mid_scan();
    int rv;
    rv = 0;
    wait_ready();
    t_cap     = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(16);
    cmd_data  = $urandom;
    step();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (rsp_valid) rv++;
    end
    chk("mid_in_shift", 64'(tgt_state), 64'd4);
    trst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    step();
    step();
    check_reset_outputs("mid_reset_held");
    chk("mid_no_rsp_valid", 64'(rv), 64'd0);
    reset_release_check();
    run_scan(16, $urandom, 1'($urandom), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    trst = 1'b1;
    repeat (2) @(posedge tck);
    #1;
    check_reset_outputs("por");
    reset_release_check();

    run_scan(8, 32'h0000_00A5, 1'b1, 1'b0);
    run_scan(1, $urandom, 1'b1, 1'b0);
    run_scan(1, $urandom, 1'b0, 1'b1);
    err_cmd(0);
    err_cmd(DATA_W + 1);
    err_cmd(63);
    tlr_test();
    run_scan(8, $urandom, 1'($urandom), 1'b0);
    run_scan(DATA_W, $urandom, 1'b1, 1'b1);
    run_scan(2, $urandom, 1'b0, 1'b1);
    for (int n = 0; n < 12; n++) begin
      run_scan(int'($urandom_range(1, DATA_W)), $urandom, 1'($urandom), 1'b1);
    end
    trst_mid_scan();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
